// File: rtl/uart_rx_8n1_if.sv
// Receive-side handshake bundle between uart_rx_8n1 (master) and the byte consumer (slave).
interface uart_rx_8n1_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_busy;
    logic       frame_err;
    logic       rx_overrun;
    logic       parity_err;

    modport master (
        output rx_data, rx_valid, rx_busy, frame_err, rx_overrun, parity_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, frame_err, rx_overrun, parity_err,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// UART receiver, 8N1 LSB first, oversampled directly on clk; held valid/ack byte output.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_8n1 #(
    parameter int CLK_PER_BIT = 625
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_rx,
    uart_rx_8n1_if.master rx_if
);

    localparam int             CNT_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [2:0]       idx_r, idx_nx_s;
    logic [7:0]       shift_r, shift_nx_s;
    logic             perr_r, perr_nx_s;
    logic             sync1_r, sync2_r, hist_r;
    logic             fall_s, done_s, ack_s;

    logic [7:0]       rx_data_r, rx_data_nx_s;
    logic             rx_valid_r, rx_valid_nx_s;
    logic             rx_busy_r;
    logic             frame_err_r, frame_err_nx_s;
    logic             rx_overrun_r, rx_overrun_nx_s;
    logic             parity_err_r, parity_err_nx_s;

    assign fall_s = hist_r & ~sync2_r;
    assign ack_s  = rx_if.rx_ack & rx_valid_r;

    // Two-flop synchronizer plus history flop; reset to 1 so the line starts out idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            hist_r  <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Frame sequencing: start validation, data bits, optional parity, stop.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        idx_nx_s   = idx_r;
        shift_nx_s = shift_r;
        perr_nx_s  = perr_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nx_s = ST_START;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_nx_s = CNT_ZERO;
                    if (sync2_r) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DATA;
                        idx_nx_s   = 3'd0;
                        perr_nx_s  = 1'b0;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_M1) begin
                    cnt_nx_s          = CNT_ZERO;
                    shift_nx_s[idx_r] = sync2_r;
                    if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx_s = ST_PARITY;
`else
                        state_nx_s = ST_STOP;
`endif
                    end else begin
                        idx_nx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == BIT_M1) begin
                    cnt_nx_s   = CNT_ZERO;
                    perr_nx_s  = (sync2_r != even_par(shift_r));
                    state_nx_s = ST_STOP;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r == BIT_M1) begin
                    cnt_nx_s   = CNT_ZERO;
                    done_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // Byte hand-off: ack frees the holding register, a clean frame fills it or flags overrun.
    always_comb begin
        rx_data_nx_s    = rx_data_r;
        rx_valid_nx_s   = rx_valid_r;
        rx_overrun_nx_s = rx_overrun_r;
        frame_err_nx_s  = 1'b0;
        parity_err_nx_s = 1'b0;
        if (rx_if.rx_ack) begin
            rx_overrun_nx_s = 1'b0;
        end else begin
            rx_overrun_nx_s = rx_overrun_r;
        end
        if (ack_s) begin
            rx_valid_nx_s = 1'b0;
        end else begin
            rx_valid_nx_s = rx_valid_r;
        end
        if (done_s) begin
            if (!sync2_r) begin
                frame_err_nx_s = 1'b1;
            end else if (perr_r) begin
                parity_err_nx_s = 1'b1;
            end else if (!rx_valid_r || ack_s) begin
                rx_data_nx_s  = shift_r;
                rx_valid_nx_s = 1'b1;
            end else begin
                rx_overrun_nx_s = 1'b1;
            end
        end else begin
            frame_err_nx_s = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            idx_r        <= 3'd0;
            shift_r      <= 8'h00;
            perr_r       <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            rx_busy_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_overrun_r <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            idx_r        <= idx_nx_s;
            shift_r      <= shift_nx_s;
            perr_r       <= perr_nx_s;
            rx_data_r    <= rx_data_nx_s;
            rx_valid_r   <= rx_valid_nx_s;
            rx_busy_r    <= (state_nx_s != ST_IDLE);
            frame_err_r  <= frame_err_nx_s;
            rx_overrun_r <= rx_overrun_nx_s;
            parity_err_r <= parity_err_nx_s;
        end
    end

    assign rx_if.rx_data    = rx_data_r;
    assign rx_if.rx_valid   = rx_valid_r;
    assign rx_if.rx_busy    = rx_busy_r;
    assign rx_if.frame_err  = frame_err_r;
    assign rx_if.rx_overrun = rx_overrun_r;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_r;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: random and directed frames against a frame-level model.
module tb_uart_rx_8n1;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    uart_rx_8n1_if rx_if ();

    uart_rx_8n1 #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_ferr = 0, exp_perr = 0, seen_ferr = 0, seen_perr = 0;
    logic [7:0] exp_q[$];
    bit model_pending = 1'b0;
    bit model_ovr = 1'b0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Model first (so the scoreboard holds the byte before the DUT shows it), then drive the line.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
        if (!stop_b) exp_ferr++;
        else if (PAR_EN && (par_b != ^b)) exp_perr++;
        else if (model_pending) model_ovr = 1'b1;
        else begin
            exp_q.push_back(b);
            model_pending = 1'b1;
        end
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (PAR_EN) begin
            uart_rx = par_b;
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        rx_if.rx_ack = 1'b1;
        @(negedge clk);
        rx_if.rx_ack = 1'b0;
        model_pending = 1'b0;
        model_ovr = 1'b0;
        check("ack_clears_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("ack_clears_overrun", {31'd0, rx_if.rx_overrun}, 32'd0);
    endtask

    // Monitor: compare each newly presented byte with the scoreboard; flags must be single-cycle.
    always @(negedge clk) begin
        if (rst_n && rx_if.rx_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte actual=%0h required=none", rx_if.rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_if.rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data actual=%0h required=%0h", rx_if.rx_data, e);
                end
            end
        end
        if (rx_if.frame_err) begin
            seen_ferr++;
            checks++;
            if (prev_ferr) begin
                errors++;
                $display("FAIL frame_err_width actual=2+ required=1");
            end
        end
        if (rx_if.parity_err) begin
            seen_perr++;
            checks++;
            if (prev_perr) begin
                errors++;
                $display("FAIL parity_err_width actual=2+ required=1");
            end
        end
        prev_valid <= rx_if.rx_valid;
        prev_ferr  <= rx_if.frame_err;
        prev_perr  <= rx_if.parity_err;
    end

    initial begin
        logic [7:0] b;
        logic bad_stop, bad_par;
        int busy_seen;
        rx_if.rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_if.rx_data}, 32'd0);
        check("rst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        check("rst_ovr", {31'd0, rx_if.rx_overrun}, 32'd0);
        check("rst_perr", {31'd0, rx_if.parity_err}, 32'd0);

        // ack with nothing pending is ignored
        do_ack();

        // 0xA5 clean frame
        b = 8'hA5;
        send_frame(b, 1'b1, ^b);
        idle(4);
        check("a5_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        check("a5_data", {24'd0, rx_if.rx_data}, 32'hA5);
        check("a5_ferr_cnt", seen_ferr, exp_ferr);
        do_ack();

        // 0x3C unacked then 0xC3 -> overrun, first byte kept
        b = 8'h3C;
        send_frame(b, 1'b1, ^b);
        idle(5);
        b = 8'hC3;
        send_frame(b, 1'b1, ^b);
        idle(4);
        check("ovr_data_kept", {24'd0, rx_if.rx_data}, 32'h3C);
        check("ovr_flag", {31'd0, rx_if.rx_overrun}, {31'd0, model_ovr});
        check("ovr_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        do_ack();

        // 6-cycle glitch
        uart_rx = 1'b0;
        busy_seen = 0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_if.rx_busy) busy_seen = 1;
        end
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_end", {31'd0, rx_if.rx_busy}, 32'd0);
        check("glitch_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("glitch_ferr_cnt", seen_ferr, exp_ferr);

        // 0x55 with bad stop, then line held low 100 clk
        b = 8'h55;
        send_frame(b, 1'b0, ^b);
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_if.rx_busy) busy_seen = 1;
        end
        check("break_ferr_cnt", seen_ferr, exp_ferr);
        check("break_no_retrigger", busy_seen, 0);
        check("break_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        idle(20);

        // reset during bit 4 of 0xFF
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        check("midrst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("midrst_data", {24'd0, rx_if.rx_data}, 32'd0);
        rst_n = 1'b1;
        idle(3 * CPB);
        check("midrst_no_byte", {31'd0, rx_if.rx_valid}, 32'd0);
        b = 8'h12;
        send_frame(b, 1'b1, ^b);
        idle(4);
        check("after_rst_data", {24'd0, rx_if.rx_data}, 32'h12);
        do_ack();

        if (PAR_EN) begin
            b = 8'h07;
            send_frame(b, 1'b1, 1'b1);
            idle(4);
            check("par_ok_valid", {31'd0, rx_if.rx_valid}, 32'd1);
            do_ack();
            send_frame(b, 1'b1, 1'b0);
            idle(4);
            check("par_bad_cnt", seen_perr, exp_perr);
            check("par_bad_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        end

        // random frames
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            bad_stop = ($urandom_range(0, 7) == 0);
            bad_par = PAR_EN && ($urandom_range(0, 7) == 0);
            send_frame(b, !bad_stop, (^b) ^ bad_par);
            idle($urandom_range(2, 20));
            check("rnd_valid", {31'd0, rx_if.rx_valid}, {31'd0, model_pending});
            check("rnd_overrun", {31'd0, rx_if.rx_overrun}, {31'd0, model_ovr});
            check("rnd_ferr_cnt", seen_ferr, exp_ferr);
            check("rnd_perr_cnt", seen_perr, exp_perr);
            if ($urandom_range(0, 3) != 0) do_ack();
        end
        do_ack();
        idle(20);
        check("scoreboard_empty", exp_q.size(), 0);
        check("final_ferr_cnt", seen_ferr, exp_ferr);
        check("final_perr_cnt", seen_perr, exp_perr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
